jt6295_hdr: RTL and testbench

- Phrase-header fetcher for JT6295.
- On a play command it reads the 6-byte phrase table entry at phrase*8 through a ROM arbiter slot port (cs/addr/dout/ok).
- It assembles the 18-bit start and stop sample addresses and hands them to the channel sequencer with a one-cycle valid pulse.
- It sits upstream of the ROM arbiter (drives slot 0, the priority slot) and downstream of the CPU command decoder.

---
 rtl/jt6295_pkg.sv | 27 ++
 rtl/jt6295_hdr.sv | 117 +++++++++++
 tb/tb_jt6295_hdr.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jt6295_pkg.sv
// Shared definitions for the JT6295 phrase-header fetcher.
package jt6295_pkg;

    // ROM address width of the MSM6295 sample space
    localparam int AW = 18;
    // Header bytes fetched per phrase
    localparam int NBYTES = 6;
    // Stride of the phrase table in bytes
    localparam int PHRASE_BYTES = 8;

    // Byte offsets inside one phrase table entry
    localparam int HDR_START_HI  = 0;
    localparam int HDR_START_MID = 1;
    localparam int HDR_START_LO  = 2;
    localparam int HDR_STOP_HI   = 3;
    localparam int HDR_STOP_MID  = 4;
    localparam int HDR_STOP_LO   = 5;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        BLANK,
        WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/jt6295_hdr.sv
// Phrase-header fetcher: reads the 6-byte table entry of a phrase through a
// ROM arbiter slot and hands the assembled start/stop addresses downstream.
module jt6295_hdr
    import jt6295_pkg::*;
#(
    parameter int AW     = jt6295_pkg::AW,
    parameter int NBYTES = jt6295_pkg::NBYTES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [6:0]    phrase,
    output logic          busy,
    output logic          rom_cs,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_dout,
    input  logic          rom_ok,
    output logic [AW-1:0] start_addr,
    output logic [AW-1:0] stop_addr,
    output logic          valid,
    output logic          bad
);

    state_t        state;
    state_t        state_nx;
    logic [6:0]    phrase_q;
    logic [2:0]    cnt;
    logic [7:0]    hdr [NBYTES];
    logic          accept;
    logic          capture;
    logic          last_byte;
    logic [9:0]    byte_addr;
    logic [AW-1:0] start_new;
    logic [AW-1:0] stop_new;

    // Table entry lives at phrase*8; the largest byte address is 0x3FD so
    // ten bits always suffice and no wrap handling is needed.
    assign byte_addr = {phrase_q, 3'b000} + {7'd0, cnt};

    // Only the low two bits of the high bytes carry address information.
    assign start_new = AW'({hdr[HDR_START_HI][1:0], hdr[HDR_START_MID], hdr[HDR_START_LO]});
    assign stop_new  = AW'({hdr[HDR_STOP_HI][1:0],  hdr[HDR_STOP_MID],  hdr[HDR_STOP_LO]});

    // Next-state logic and per-cycle strobes
    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        capture   = 1'b0;
        last_byte = (cnt == 3'(NBYTES - 1));
        case (state)
            IDLE: begin
                // busy is still high in the valid cycle, so a start there is dropped
                if (start && !busy) begin
                    accept   = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: state_nx = BLANK;
            // ok seen here may still belong to the previous byte
            BLANK: state_nx = WAIT;
            WAIT: begin
                if (rom_ok) begin
                    capture  = 1'b1;
                    state_nx = last_byte ? DONE : ISSUE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Control, ROM slot and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_cs     <= 1'b0;
            rom_addr   <= '0;
            start_addr <= '0;
            stop_addr  <= '0;
            valid      <= 1'b0;
            bad        <= 1'b0;
            busy       <= 1'b0;
            cnt        <= '0;
            phrase_q   <= '0;
        end else begin
            valid <= 1'b0;
            busy  <= (state_nx != IDLE) || (state == DONE);
            if (accept) begin
                phrase_q <= phrase;
                cnt      <= '0;
            end
            if (state == ISSUE) begin
                rom_addr <= AW'(byte_addr);
                rom_cs   <= 1'b1;
            end
            if (capture && !last_byte) cnt <= cnt + 3'd1;
            if (state == DONE) begin
                rom_cs     <= 1'b0;
                valid      <= 1'b1;
                start_addr <= start_new;
                stop_addr  <= stop_new;
                bad        <= (phrase_q == 7'd0) || (stop_new < start_new);
            end
        end
    end

    // Header byte capture; contents are discarded on abort so no reset needed
    always_ff @(posedge clk) begin
        if (capture) hdr[cnt] <= rom_dout;
    end

endmodule

// File: tb/tb_jt6295_hdr.sv
// Bench for jt6295_hdr: ROM arbiter model, scoreboard of expected headers,
// and a monitor that checks every valid pulse.
module tb_jt6295_hdr;

    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [6:0]    phrase;
    logic          busy;
    logic          rom_cs;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_dout;
    logic          rom_ok;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] stop_addr;
    logic          valid;
    logic          bad;

    jt6295_hdr dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .phrase     (phrase),
        .busy       (busy),
        .rom_cs     (rom_cs),
        .rom_addr   (rom_addr),
        .rom_dout   (rom_dout),
        .rom_ok     (rom_ok),
        .start_addr (start_addr),
        .stop_addr  (stop_addr),
        .valid      (valid),
        .bad        (bad)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [17:0] s;
        logic [17:0] e;
        logic        b;
        int          c0;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [17:0] addr_q[$];
    logic [7:0]  mem [0:1023];
    int          rom_lat = 0;
    bit          rom_stale = 1'b0;
    int          wcnt = 0;
    logic [17:0] last_addr = '1;
    int          nvalid = 0;
    exp_t        mon_e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // ROM arbiter slot model: ok drops after an address change (or stays
    // stale for one cycle in stale mode), then returns after rom_lat cycles.
    always @(posedge clk) begin
        #1;
        if (rst || !rom_cs) begin
            rom_ok    = 1'b0;
            last_addr = '1;
            wcnt      = 0;
        end else if (rom_addr != last_addr) begin
            if (addr_q.size() == 0) chk("rom_addr_unexpected", rom_addr, 32'hFFFF_FFFF);
            else                    chk("rom_addr", rom_addr, addr_q.pop_front());
            last_addr = rom_addr;
            wcnt      = rom_lat;
            if (!rom_stale) rom_ok = 1'b0;
        end else if (wcnt > 0) begin
            wcnt--;
            rom_ok = 1'b0;
        end else begin
            rom_ok   = 1'b1;
            rom_dout = mem[last_addr[9:0]];
        end
    end

    // Monitor: every valid pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (valid) begin
            nvalid++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL valid_unexpected start_addr=%0h stop_addr=%0h required=none", start_addr, stop_addr);
            end else begin
                mon_e = sb.pop_front();
                chk("start_addr", start_addr, mon_e.s);
                chk("stop_addr", stop_addr, mon_e.e);
                chk("bad", bad, mon_e.b);
                chk("latency", cyc - mon_e.c0, mon_e.lat);
            end
        end
    end

    task automatic fetch(input logic [6:0] ph, input int lat, input bit stl, input bit inject);
        exp_t e;
        int   hb[6];
        int   s;
        int   p;
        int   k;
        bit   seen;
        rom_lat   = lat;
        rom_stale = stl;
        for (int i = 0; i < 6; i++) begin
            hb[i] = int'(mem[int'(ph) * 8 + i]);
            addr_q.push_back(18'(int'(ph) * 8 + i));
        end
        s   = (hb[0] % 4) * 65536 + hb[1] * 256 + hb[2];
        p   = (hb[3] % 4) * 65536 + hb[4] * 256 + hb[5];
        e.s = 18'(s);
        e.e = 18'(p);
        e.b = (ph == 7'd0) || (p < s);
        @(negedge clk);
        e.c0  = cyc;
        e.lat = 20 + 6 * lat;
        sb.push_back(e);
        start  = 1'b1;
        phrase = ph;
        @(negedge clk);
        start  = 1'b0;
        phrase = 7'($urandom);
        seen   = 1'b0;
        for (int t = 0; t < 400 && !seen; t++) begin
            k = cyc - e.c0;
            if (k <= e.lat) chk("busy", busy, 1);
            if (k >= 2 && k < e.lat) chk("rom_cs_held", rom_cs, 1);
            if (inject && (k == 5 || k == 19)) begin
                start  = 1'b1;
                phrase = 7'd3;
            end else begin
                start = 1'b0;
            end
            if (valid) seen = 1'b1;
            else @(negedge clk);
        end
        start = 1'b0;
        if (!seen) begin
            chk("valid_timeout", 0, 1);
            sb.delete();
            addr_q.delete();
        end
        @(negedge clk);
        chk("busy_clear", busy, 0);
        chk("valid_single", valid, 0);
        chk("rom_cs_release", rom_cs, 0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rom_cs"}, rom_cs, 0);
        chk({tag, "_rom_addr"}, rom_addr, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_start_addr"}, start_addr, 0);
        chk({tag, "_stop_addr"}, stop_addr, 0);
        chk({tag, "_bad"}, bad, 0);
    endtask

    initial begin
        int          n0;
        logic [17:0] base;
        bit          found;
        rst    = 1'b1;
        start  = 1'b0;
        phrase = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        // phrase 1: start 0x00400, stop 0x007FF
        mem[8]  = 8'h00; mem[9]  = 8'h04; mem[10] = 8'h00;
        mem[11] = 8'h00; mem[12] = 8'h07; mem[13] = 8'hFF;
        // phrase 2: high bits of b0/b3 must be ignored
        mem[16] = 8'hFF; mem[17] = 8'h12; mem[18] = 8'h34;
        mem[19] = 8'hFE; mem[20] = 8'h56; mem[21] = 8'h78;
        // phrase 5: stop below start
        mem[40] = 8'h00; mem[41] = 8'h10; mem[42] = 8'h00;
        mem[43] = 8'h00; mem[44] = 8'h08; mem[45] = 8'h00;

        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        fetch(7'd1, 0, 1'b0, 1'b0);
        fetch(7'd2, 0, 1'b0, 1'b0);
        fetch(7'd1, 3, 1'b1, 1'b0);
        fetch(7'd0, 0, 1'b0, 1'b0);
        fetch(7'd5, 1, 1'b0, 1'b0);

        n0 = nvalid;
        fetch(7'd1, 0, 1'b0, 1'b1);
        repeat (25) @(negedge clk);
        chk("valid_count_ignored_start", nvalid - n0, 1);

        // abort during the WAIT of byte 3
        rom_lat   = 4;
        rom_stale = 1'b0;
        base      = 18'(9 * 8);
        for (int i = 0; i < 4; i++) addr_q.push_back(base + 18'(i));
        @(negedge clk);
        start  = 1'b1;
        phrase = 7'd9;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 200 && !found; t++) begin
            if (rom_cs && rom_addr == base + 18'd3) found = 1'b1;
            else @(negedge clk);
        end
        chk("abort_reached_byte3", found, 1);
        repeat (2) @(negedge clk);
        n0  = nvalid;
        rst = 1'b1;
        @(negedge clk);
        chk_reset_state("abort");
        rst = 1'b0;
        addr_q.delete();
        repeat (30) @(negedge clk);
        chk("no_valid_after_abort", nvalid - n0, 0);

        fetch(7'd1, 0, 1'b0, 1'b0);

        for (int r = 0; r < 10; r++) begin
            fetch(7'($urandom_range(0, 127)), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
